// File: rtl/divide_tokens_if.sv
// Token and configuration bundle for divide_tokens.
// The master side drives tokens and configuration; the slave side returns
// the registered per-channel output tokens and the global emitted count.
interface divide_tokens_if #(
    parameter int CH      = 4,
    parameter int RATIO_W = 4,
    parameter int CNT_W   = 16
);
    localparam int CFG_W = (CH > 1) ? $clog2(CH) : 1;

    logic [CH-1:0]      a;
    logic               cfg_we;
    logic [CFG_W-1:0]   cfg_ch;
    logic [RATIO_W-1:0] cfg_ratio;
    logic               flush;
    logic [CH-1:0]      b;
    logic [CNT_W-1:0]   emitted;

    modport master (
        output a, cfg_we, cfg_ch, cfg_ratio, flush,
        input  b, emitted
    );

    modport slave (
        input  a, cfg_we, cfg_ch, cfg_ratio, flush,
        output b, emitted
    );
endinterface

// File: rtl/divide_tokens.sv
// Multi-channel token rate divider: each channel emits one output token for
// every ratio-th input token. A ratio write or a flush restarts the count,
// and the same-cycle token is evaluated as the first token from count 0.
module divide_tokens #(
    parameter int CH        = 4,
    parameter int RATIO_W   = 4,
    parameter int RST_RATIO = 2,
    parameter int CNT_W     = 16
) (
    input logic            clk,
    input logic            rst_n,
    divide_tokens_if.slave bus
);
    logic [RATIO_W-1:0] ratio_q    [CH];
    logic [RATIO_W-1:0] count_q    [CH];
    logic [RATIO_W-1:0] ratio_d    [CH];
    logic [RATIO_W-1:0] base_count [CH];
    logic [RATIO_W-1:0] count_d    [CH];
    logic [CH-1:0]      wr_hit;
    logic [CH-1:0]      fire;
    logic [CNT_W-1:0]   pop;

    // Decode which channel a config write targets; out-of-range indices match none.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves a value unassigned (which would infer a latch).
        wr_hit = '0;
        for (int i = 0; i < CH; i++) begin
            wr_hit[i] = bus.cfg_we && (32'(bus.cfg_ch) == i);
        end
    end

    // Per-channel next ratio/count and fire decision, then the fire popcount.
    always_comb begin
        fire = '0;
        pop  = '0;
        for (int i = 0; i < CH; i++) begin
            ratio_d[i]    = wr_hit[i] ? bus.cfg_ratio : ratio_q[i];
            base_count[i] = (wr_hit[i] || bus.flush) ? '0 : count_q[i];
            count_d[i]    = base_count[i];
            if (ratio_d[i] == '0) begin
                count_d[i] = '0;
            end else if (ratio_d[i] == RATIO_W'(1)) begin
                count_d[i] = '0;
                fire[i]    = bus.a[i];
            end else if (bus.a[i]) begin
                if (base_count[i] == ratio_d[i] - RATIO_W'(1)) begin
                    count_d[i] = '0;
                    fire[i]    = 1'b1;
                end else begin
                    count_d[i] = base_count[i] + RATIO_W'(1);
                end
            end
            pop = pop + CNT_W'(fire[i]);
        end
    end

    // Register channel state, output tokens and the wrapping emitted count.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                ratio_q[i] <= RATIO_W'(RST_RATIO);
                count_q[i] <= '0;
            end
            bus.b       <= '0;
            bus.emitted <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                ratio_q[i] <= ratio_d[i];
                count_q[i] <= count_d[i];
            end
            bus.b       <= fire;
            bus.emitted <= bus.emitted + pop;
        end
    end
endmodule

// File: tb/tb_divide_tokens.sv
// Self-checking bench for divide_tokens: directed scenarios with hand-computed
// expectations, then randomized traffic checked every cycle against a
// token-counting model. Two DUTs share stimulus: 16-bit and 4-bit counters.
module tb_divide_tokens;
    localparam int CH = 4;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] a = '0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_ch = '0;
    logic [RW-1:0] cfg_ratio = '0;
    logic          flush = 1'b0;
    logic          chk_en = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    // Model state: ratio and tokens seen since the last clear per channel.
    int            m_ratio [CH];
    int            m_tok   [CH];
    logic [CH-1:0] exp_b = '0;
    int            exp_em = 0;

    divide_tokens_if #(.CH(CH), .RATIO_W(RW), .CNT_W(16)) bus16 ();
    divide_tokens_if #(.CH(CH), .RATIO_W(RW), .CNT_W(4))  bus4 ();

    assign bus16.a = a;         assign bus4.a = a;
    assign bus16.cfg_we = cfg_we;       assign bus4.cfg_we = cfg_we;
    assign bus16.cfg_ch = cfg_ch;       assign bus4.cfg_ch = cfg_ch;
    assign bus16.cfg_ratio = cfg_ratio; assign bus4.cfg_ratio = cfg_ratio;
    assign bus16.flush = flush;         assign bus4.flush = flush;

    divide_tokens #(.CH(CH), .RATIO_W(RW), .RST_RATIO(2), .CNT_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(bus16.slave)
    );
    divide_tokens #(.CH(CH), .RATIO_W(RW), .RST_RATIO(2), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A channel fires on every token whose running total since the last
    // clear is a multiple of its ratio; ratio 0 drops tokens.
    task automatic model_step();
        logic [CH-1:0] nb;
        nb = '0;
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                m_ratio[i] = 2;
                m_tok[i]   = 0;
            end
            exp_b  = '0;
            exp_em = 0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (cfg_we && int'(cfg_ch) == i) begin
                    m_ratio[i] = int'(cfg_ratio);
                    m_tok[i]   = 0;
                end
                if (flush) m_tok[i] = 0;
                if (a[i] && m_ratio[i] != 0) begin
                    m_tok[i]++;
                    if (m_tok[i] % m_ratio[i] == 0) nb[i] = 1'b1;
                end
            end
            exp_b  = nb;
            exp_em = exp_em + $countones(nb);
        end
    endtask

    // Apply one cycle of stimulus; on return the DUT outputs for it are visible.
    task automatic cyc(input logic [CH-1:0] av, input logic we = 1'b0,
                       input int ch = 0, input int r = 0, input logic fl = 1'b0);
        a         = av;
        cfg_we    = we;
        cfg_ch    = 2'(ch);
        cfg_ratio = RW'(r);
        flush     = fl;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("b16", int'(bus16.b), int'(exp_b));
            check("b4", int'(bus4.b), int'(exp_b));
            check("emitted16", int'(bus16.emitted), exp_em % 65536);
            check("emitted4", int'(bus4.emitted), exp_em % 16);
        end
    end

    initial begin
        logic [15:0] s1;
        logic [15:0] got1;
        logic [8:0]  got2;
        logic [3:0]  s3;
        logic [3:0]  got3b, got3c;

        // Reset defaults.
        rst_n = 1'b0;
        cyc(4'hF, 1'b1, 1, 0, 1'b1);
        chk_en = 1'b1;
        cyc(4'h0);
        check("rst_b", int'(bus16.b), 0);
        check("rst_emitted", int'(bus16.emitted), 0);
        rst_n = 1'b1;

        // Channel 0 at the reset ratio of 2 (time order = MSB first).
        s1 = 16'b1100_1110_1000_1111;
        got1 = '0;
        for (int k = 0; k < 16; k++) begin
            cyc({3'b000, s1[15-k]});
            got1[15-k] = bus16.b[0];
        end
        check("t1_b0_stream", int'(got1), 16'h4485);
        check("t1_emitted", int'(bus16.emitted), 5);
        check("t1_model_emitted", exp_em, 5);

        // Ratio 3 on channel 1: pulses on tokens 3, 6 and 9.
        cyc(4'h0, 1'b1, 1, 3);
        got2 = '0;
        for (int k = 0; k < 9; k++) begin
            cyc(4'b0010);
            got2[8-k] = bus16.b[1];
        end
        check("t2_b1_stream", int'(got2), 9'b001_001_001);
        check("t2_emitted", int'(bus16.emitted), 8);

        // Ratio 0 on channel 2 blocks; ratio 1 on channel 3 passes everything.
        cyc(4'h0, 1'b1, 2, 0);
        cyc(4'h0, 1'b1, 3, 1);
        s3 = 4'b1011;
        got3b = '0;
        got3c = '0;
        for (int k = 0; k < 4; k++) begin
            cyc({s3[3-k], s3[3-k], 2'b00});
            got3b[3-k] = bus16.b[2];
            got3c[3-k] = bus16.b[3];
        end
        check("t3_b2_blocked", int'(got3b), 0);
        check("t3_b3_stream", int'(got3c), 4'b1011);
        check("t3_emitted", int'(bus16.emitted), 11);

        // Config mid-stream: partial count 1 at ratio 2, then write ratio 1 with a token.
        cyc(4'b0001);
        check("t4_partial", int'(bus16.b[0]), 0);
        cyc(4'b0001, 1'b1, 0, 1);
        check("t4_cfg_fire", int'(bus16.b[0]), 1);
        cyc(4'b0001, 1'b1, 0, 2);
        check("t4_restart", int'(bus16.b[0]), 0);
        cyc(4'b0001);
        check("t4_second", int'(bus16.b[0]), 1);
        check("t4_emitted", int'(bus16.emitted), 13);

        // Flush clears partial counts; without flush all four fire together.
        for (int c = 0; c < CH; c++) cyc(4'h0, 1'b1, c, 2);
        cyc(4'hF);
        cyc(4'h0, 1'b0, 0, 0, 1'b1);
        cyc(4'hF);
        check("t5_flushed", int'(bus16.b), 0);
        cyc(4'hF);
        check("t5_all_fire", int'(bus16.b), 4'hF);
        check("t5_emitted", int'(bus16.emitted), 17);

        // Ratio 1 everywhere with tokens held: 20 emissions wrap the 4-bit counter.
        for (int c = 0; c < CH; c++) cyc(4'h0, 1'b1, c, 1);
        for (int k = 0; k < 5; k++) cyc(4'hF);
        check("t6_emitted16", int'(bus16.emitted), 37);
        check("t6_emitted4_wrap", int'(bus4.emitted), 5);
        rst_n = 1'b0;
        cyc(4'hF);
        check("t6_rst_b", int'(bus16.b), 0);
        check("t6_rst_emitted16", int'(bus16.emitted), 0);
        check("t6_rst_emitted4", int'(bus4.emitted), 0);
        rst_n = 1'b1;

        // Randomized traffic including config, flush and occasional reset.
        for (int k = 0; k < 600; k++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            cyc(4'($urandom), ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 5)), ($urandom_range(0, 9) == 0));
        end
        rst_n = 1'b1;
        cyc(4'h0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
